// File: rtl/mandel_cmd_rx.sv
// mandel_cmd_rx -- UART 8N1 command packet receiver.
//
// Receives bytes on rxd and assembles NUM_BYTES-byte command packets for the
// Mandelbrot engine. The first byte received ends up in the top byte of
// pkt_data. A completed packet is held on pkt_data/pkt_valid until the
// consumer accepts it. The line is never back-pressured: a packet that
// completes while the previous one is still held is dropped.
//
// Optional build macro: MANDEL_CMD_RX_CHECKSUM_EN
//   When defined, every packet carries one extra trailing checksum byte. The
//   packet is delivered only if the 8-bit sum of all bytes, including the
//   checksum, is zero. The checksum byte never appears in pkt_data. When the
//   macro is undefined, chk_err is tied low. The port list is the same in both
//   builds.
//
// Parameters
//   CLKS_PER_BIT  clocks per UART bit (>= 4)
//   NUM_BYTES     payload bytes per packet (>= 2)
//   TIMEOUT_CLKS  idle clocks between bytes before a partial packet is dropped
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   rxd        in   UART serial input, idle high, asynchronous to clk
//   pkt_ready  in   consumer accepts the held packet (with pkt_valid)
//   pkt_data   out  assembled packet, first byte in [NUM_BYTES*8-1 -: 8]
//   pkt_valid  out  packet held, stays high until accepted
//   busy       out  partial packet in progress or a frame is being decoded
//   frm_err    out  1-cycle pulse: stop bit sampled low
//   tmo_err    out  1-cycle pulse: partial packet abandoned after idle time
//   ovr_err    out  1-cycle pulse: packet completed while one was held
//   chk_err    out  1-cycle pulse: checksum mismatch (checksum build only)
//   dbg_state  out  receive FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Handshake: the packet transfers on a rising edge where pkt_valid and
// pkt_ready are both high. pkt_valid drops on that edge unless a new packet
// completes on the same edge, in which case pkt_valid stays high and pkt_data
// takes the new packet. pkt_data changes only when a packet is delivered.

module mandel_cmd_rx #(
  parameter int CLKS_PER_BIT = 26,
  parameter int NUM_BYTES    = 10,
  parameter int TIMEOUT_CLKS = 16384
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  input  logic                   pkt_ready,
  output logic [NUM_BYTES*8-1:0] pkt_data,
  output logic                   pkt_valid,
  output logic                   busy,
  output logic                   frm_err,
  output logic                   tmo_err,
  output logic                   ovr_err,
  output logic                   chk_err,
  output logic [1:0]             dbg_state
);

`ifdef MANDEL_CMD_RX_CHECKSUM_EN
  localparam int PKT_LEN = NUM_BYTES + 1;
`else
  localparam int PKT_LEN = NUM_BYTES;
`endif

  localparam int PW   = NUM_BYTES * 8;
  // Bytes held before the final byte of a packet arrives.
  localparam int ASMW = (PKT_LEN - 1) * 8;
  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int IDXW = $clog2(PKT_LEN + 1);
  localparam int TW   = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(PKT_LEN - 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic            rxd_s1_q, rxd_s2_q;
  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_done_q, byte_done_d;
  logic [IDXW-1:0] byte_idx_q, byte_idx_d;
  logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            wait_high_q, wait_high_d;
  logic [ASMW-1:0] asm_q, asm_d;
  logic [PW-1:0]   pkt_data_q, pkt_data_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            frm_err_q, frm_err_d;
  logic            tmo_err_q, tmo_err_d;
  logic            ovr_err_q, ovr_err_d;
  logic [PW-1:0]   pkt_next;
  logic            deliver;

`ifdef MANDEL_CMD_RX_CHECKSUM_EN
  logic [7:0] sum_q, sum_d, sum_next;
  logic       chk_err_q, chk_err_d;
  // The checksum byte is the last one received and is never stored.
  assign pkt_next = asm_q;
  assign sum_next = sum_q + shift_q;
`else
  assign pkt_next = {asm_q, shift_q};
`endif

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = 1'b0;
    byte_idx_d  = byte_idx_q;
    idle_cnt_d  = idle_cnt_q;
    wait_high_d = wait_high_q;
    asm_d       = asm_q;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = pkt_valid_q;
    frm_err_d   = 1'b0;
    tmo_err_d   = 1'b0;
    ovr_err_d   = 1'b0;
    deliver     = 1'b0;
`ifdef MANDEL_CMD_RX_CHECKSUM_EN
    sum_d       = sum_q;
    chk_err_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (rxd_s2_q) wait_high_d = 1'b0;
        if (!rxd_s2_q && !wait_high_q) begin
          state_d    = S_START;
          clk_cnt_d  = '0;
          idle_cnt_d = '0;
        end else if (byte_idx_q != '0 && !byte_done_q) begin
          // Only gaps inside a packet are timed.
          if (idle_cnt_q == TMO_LAST) begin
            tmo_err_d  = 1'b1;
            byte_idx_d = '0;
            idle_cnt_d = '0;
`ifdef MANDEL_CMD_RX_CHECKSUM_EN
            sum_d      = '0;
`endif
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      S_START: begin
        // Re-check the start bit half a bit in; a glitch goes back to IDLE.
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rxd_s2_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rxd_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
          else                   bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        // Leave at mid stop bit so a start bit right after it is not missed.
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
          if (rxd_s2_q) begin
            byte_done_d = 1'b1;
          end else begin
            frm_err_d   = 1'b1;
            byte_idx_d  = '0;
            // The line is still low; wait for it to go high before re-arming.
            wait_high_d = 1'b1;
`ifdef MANDEL_CMD_RX_CHECKSUM_EN
            sum_d       = '0;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Byte bookkeeping runs one clock after the stop sample.
    if (byte_done_q) begin
      if (byte_idx_q == LAST_IDX) begin
        byte_idx_d = '0;
`ifdef MANDEL_CMD_RX_CHECKSUM_EN
        sum_d = '0;
        if (sum_next != 8'h00) chk_err_d = 1'b1;
        else                   deliver   = 1'b1;
`else
        deliver = 1'b1;
`endif
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
        asm_d      = {asm_q[ASMW-9:0], shift_q};
`ifdef MANDEL_CMD_RX_CHECKSUM_EN
        sum_d      = sum_next;
`endif
      end
    end

    if (deliver) begin
      if (pkt_valid_q && !pkt_ready) begin
        ovr_err_d = 1'b1;
      end else begin
        pkt_data_d  = pkt_next;
        pkt_valid_d = 1'b1;
      end
    end else if (pkt_valid_q && pkt_ready) begin
      pkt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      byte_idx_q  <= '0;
      idle_cnt_q  <= '0;
      wait_high_q <= 1'b0;
      asm_q       <= '0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      frm_err_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
      ovr_err_q   <= 1'b0;
`ifdef MANDEL_CMD_RX_CHECKSUM_EN
      sum_q       <= '0;
      chk_err_q   <= 1'b0;
`endif
    end else begin
      rxd_s1_q    <= rxd;
      rxd_s2_q    <= rxd_s1_q;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      byte_idx_q  <= byte_idx_d;
      idle_cnt_q  <= idle_cnt_d;
      wait_high_q <= wait_high_d;
      asm_q       <= asm_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      frm_err_q   <= frm_err_d;
      tmo_err_q   <= tmo_err_d;
      ovr_err_q   <= ovr_err_d;
`ifdef MANDEL_CMD_RX_CHECKSUM_EN
      sum_q       <= sum_d;
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  assign pkt_data  = pkt_data_q;
  assign pkt_valid = pkt_valid_q;
  assign busy      = (byte_idx_q != '0) || (state_q != S_IDLE);
  assign frm_err   = frm_err_q;
  assign tmo_err   = tmo_err_q;
  assign ovr_err   = ovr_err_q;
  assign dbg_state = state_q;
`ifdef MANDEL_CMD_RX_CHECKSUM_EN
  assign chk_err   = chk_err_q;
`else
  assign chk_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mandel_cmd_rx.sv
`timescale 1ns/1ps
module tb_mandel_cmd_rx;
  localparam int CPB = 26;
  localparam int NB  = 10;
  localparam int TMO = 16384;
  localparam int PW  = NB * 8;
`ifdef MANDEL_CMD_RX_CHECKSUM_EN
  localparam int PKT_LEN = NB + 1;
`else
  localparam int PKT_LEN = NB;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rxd = 1'b1;
  logic          pkt_ready = 1'b0;
  logic [PW-1:0] pkt_data;
  logic          pkt_valid, busy, frm_err, tmo_err, ovr_err, chk_err;
  logic [1:0]    dbg_state;

  always #20 clk = ~clk;

  mandel_cmd_rx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .pkt_ready(pkt_ready),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .busy(busy),
    .frm_err(frm_err), .tmo_err(tmo_err), .ovr_err(ovr_err),
    .chk_err(chk_err), .dbg_state(dbg_state)
  );

  // ---------------- behavioural model / scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];   // packet the consumer should currently see
  logic [7:0]    asm_m[$];   // bytes of the packet in progress
  int exp_frm = 0, exp_tmo = 0, exp_ovr = 0, exp_chk = 0;
  int dut_frm = 0, dut_tmo = 0, dut_ovr = 0, dut_chk = 0;
  bit settled = 1'b0;        // model is up to date with the line

  function automatic void check(input string name, input logic [PW-1:0] act,
                                input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] model_sum();
    logic [7:0] s = 8'h00;
    foreach (asm_m[i]) s += asm_m[i];
    return s;
  endfunction

  // A received byte joins the packet; a full packet is judged by the rules.
  function automatic void model_byte(input logic [7:0] b);
    logic [PW-1:0] p;
    bit ok;
    asm_m.push_back(b);
    if (asm_m.size() == PKT_LEN) begin
      p = '0;
      for (int i = 0; i < NB; i++) p = (p << 8) | PW'(asm_m[i]);
      ok = 1'b1;
`ifdef MANDEL_CMD_RX_CHECKSUM_EN
      if (model_sum() != 8'h00) begin
        ok = 1'b0;
        exp_chk++;
      end
`endif
      if (ok) begin
        if (exp_q.size() != 0) exp_ovr++;
        else exp_q.push_back(p);
      end
      asm_m.delete();
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (frm_err) dut_frm++;
      if (tmo_err) dut_tmo++;
      if (ovr_err) dut_ovr++;
      if (chk_err) dut_chk++;
      if (settled) begin
        check("pkt_valid", PW'(pkt_valid), PW'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("pkt_data", pkt_data, exp_q[0]);
        check("busy", PW'(busy), PW'(asm_m.size() != 0));
        check("frm_cnt", PW'(dut_frm), PW'(exp_frm));
        check("tmo_cnt", PW'(dut_tmo), PW'(exp_tmo));
        check("ovr_cnt", PW'(dut_ovr), PW'(exp_ovr));
        check("chk_cnt", PW'(dut_chk), PW'(exp_chk));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    settled = 1'b0;
    rst = 1'b0;
    rxd = 1'b1;
    pkt_ready = 1'b0;
    tick(3);
    check("rst_pkt_valid", PW'(pkt_valid), '0);
    check("rst_pkt_data", pkt_data, '0);
    check("rst_busy", PW'(busy), '0);
    check("rst_errs", PW'({frm_err, tmo_err, ovr_err, chk_err}), '0);
    check("rst_state", PW'(dbg_state), '0);
    asm_m.delete();
    exp_q.delete();
    rst = 1'b1;
    tick(4);
    settled = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    settled = 1'b0;
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_ok;
    tick(CPB);
    rxd = 1'b1;
    if (stop_ok) begin
      model_byte(b);
    end else begin
      exp_frm++;
      asm_m.delete();
    end
    settled = 1'b1;
  endtask

  task automatic idle(input int n);
    if (n > TMO) begin
      settled = 1'b0;
      tick(n);
      if (asm_m.size() != 0) begin
        exp_tmo++;
        asm_m.delete();
      end
      settled = 1'b1;
    end else begin
      tick(n);
    end
  endtask

  task automatic send_pkt(input logic [PW-1:0] p, input int gap);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < NB; i++) begin
      send_byte(p[PW-1-8*i -: 8], 1'b1);
      s += p[PW-1-8*i -: 8];
      idle(gap);
    end
`ifdef MANDEL_CMD_RX_CHECKSUM_EN
    send_byte(8'h00 - s, 1'b1);
    idle(gap);
`endif
  endtask

  task automatic accept();
    settled = 1'b0;
    pkt_ready = 1'b1;
    tick(1);
    pkt_ready = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    settled = 1'b1;
  endtask

  task automatic false_start();
    settled = 1'b0;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(CPB + 4);
    settled = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [PW-1:0] p1, p2;

  initial begin
    p1 = 80'h0308F000F80000400040;
    p2 = 80'h0102030405060708090A;
    tick(1);
    do_reset();

    // Packet held while not ready, then released by one ready cycle.
    send_pkt(p1, CPB);
    idle(100);
    check("p1_data", pkt_data, p1);
    check("p1_model", (exp_q.size() == 1) ? exp_q[0] : '0, p1);
    check("p1_valid", PW'(pkt_valid), PW'(1));
    idle(200);
    check("p1_held", PW'(pkt_valid), PW'(1));
    accept();
    check("p1_released", PW'(pkt_valid), '0);

    // Back-to-back frames.
    send_pkt(p1, 0);
    idle(60);
    check("b2b_data", pkt_data, p1);
    check("b2b_no_frm", PW'(dut_frm), '0);
    accept();

    // Framing error on a mid-packet byte discards the partial packet.
    send_byte(8'h01, 1'b1);
    idle(CPB);
    send_byte(8'h02, 1'b1);
    idle(CPB);
    send_byte(8'h03, 1'b0);
    idle(60);
    check("frm_once", PW'(dut_frm), PW'(1));
    check("frm_busy", PW'(busy), '0);
    send_pkt(p2, CPB);
    idle(60);
    check("p2_data", pkt_data, p2);
    accept();

    // Timeout after four bytes.
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(8'hA0 + i), 1'b1);
      idle(CPB);
    end
    idle(20000);
    check("tmo_once", PW'(dut_tmo), PW'(1));
    check("tmo_busy", PW'(busy), '0);
    send_pkt(p1, CPB);
    idle(60);
    check("after_tmo_data", pkt_data, p1);
    accept();

    // Overrun: second packet dropped while first still held.
    send_pkt(p1, CPB);
    idle(60);
    send_pkt(p2, CPB);
    idle(60);
    check("ovr_once", PW'(dut_ovr), PW'(1));
    check("ovr_data_kept", pkt_data, p1);
    accept();

`ifdef MANDEL_CMD_RX_CHECKSUM_EN
    // Good checksum 0xC9 is produced by send_pkt; then a bad one.
    check("chk_model", PW'(8'h00 - 8'h37), PW'(8'hC9));
    send_pkt(p2, CPB);
    idle(60);
    check("chk_good_data", pkt_data, p2);
    accept();
    for (int i = 0; i < NB; i++) begin
      send_byte(p2[PW-1-8*i -: 8], 1'b1);
      idle(CPB);
    end
    send_byte(8'hC8, 1'b1);
    idle(60);
    check("chk_bad_cnt", PW'(dut_chk), PW'(1));
    check("chk_bad_valid", PW'(pkt_valid), '0);
`endif

    // Reset in the middle of a packet and in the middle of a frame.
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h55, 1'b1);
      idle(CPB);
    end
    settled = 1'b0;
    rxd = 1'b0;
    tick(CPB * 4);
    do_reset();
    send_pkt(p2, CPB);
    idle(60);
    check("after_rst_data", pkt_data, p2);
    accept();

    // Randomised traffic.
    for (int it = 0; it < 40; it++) begin
      int r, g;
      logic [7:0] b;
      bit ok;
      r = $urandom_range(0, 99);
      if (r < 15) accept();
      else if (r < 22) false_start();
      b = 8'($urandom_range(0, 255));
`ifdef MANDEL_CMD_RX_CHECKSUM_EN
      if (asm_m.size() == PKT_LEN - 1 && $urandom_range(0, 1) == 1) b = 8'h00 - model_sum();
`endif
      ok = ($urandom_range(0, 99) >= 8);
      send_byte(b, ok);
      if (!ok) g = $urandom_range(30, 150);
      else if ($urandom_range(0, 3) == 0) g = 0;
      else g = $urandom_range(1, 150);
      idle(g);
    end
    idle(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(40 * 150000);
    $display("FAIL watchdog act=running exp=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mandel_cmd_rx.md
MANDEL_CMD_RX -- requirements
Module: mandel_cmd_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 26, clocks per UART bit (25 MHz / 26 = 961538 baud).
REQ-002 SHALL have parameter NUM_BYTES, default 10, payload bytes per command packet (pix_x, pix_y, cxs H/L, cys H/L, dcx H/L, dcy H/L).
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 16384, idle clocks between bytes before a partial packet is abandoned.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 rxd  input  1  UART 8N1 serial input, idle high, asynchronous to clk.
REQ-007 pkt_data  output  NUM_BYTES*8  assembled packet; first received byte in bits [NUM_BYTES*8-1 -: 8].
REQ-008 pkt_valid  output  1  packet available; held until accepted.
REQ-009 pkt_ready  input  1  consumer accepts packet when pkt_valid and pkt_ready are both high on a rising edge.
REQ-010 busy  output  1  high while a packet is partially received (byte index > 0 or state != IDLE).
REQ-011 frm_err, tmo_err, ovr_err, chk_err  output  1 each  single-cycle error pulses.

Function
REQ-012 rxd SHALL pass through a 2-flop synchroniser, both flops resetting to 1; all decoding uses the synchronised value.
REQ-013 FSM states IDLE, START, DATA, STOP; IDLE->START on synchronised rxd low.
REQ-014 START: sample at CLKS_PER_BIT/2 clocks; low -> DATA, high -> IDLE (false start, no error, no byte).
REQ-015 DATA: 8 samples, each CLKS_PER_BIT clocks after the previous, LSB first.
REQ-016 STOP: sample CLKS_PER_BIT clocks after bit 7; high -> byte stored, FSM to IDLE on the next clock (no wait for end of stop bit, so back-to-back frames are received).
REQ-017 STOP sampled low -> frm_err pulse, partial packet discarded (byte index to 0), FSM to IDLE, and a new start is accepted only after rxd is seen high.
REQ-018 Byte index counts 0..NUM_BYTES-1; storing the last byte SHALL raise pkt_valid one clock after the stop sample and return index to 0.
REQ-019 pkt_data SHALL update only when a complete packet is delivered; it is stable while pkt_valid is high.
REQ-020 pkt_valid SHALL clear on the clock after acceptance; if a new packet completes on the same clock as acceptance, pkt_valid stays high with the new data.
REQ-021 A packet completing while pkt_valid=1 and pkt_ready=0 SHALL be dropped with an ovr_err pulse; held data is unchanged.
REQ-022 While byte index > 0 and FSM in IDLE, an idle counter SHALL count; at TIMEOUT_CLKS -> tmo_err pulse, index to 0; counter clears on any start detection.
REQ-023 Reception SHALL continue independently of pkt_valid/pkt_ready (no backpressure to the line).

Reset
REQ-024 On rst low, asynchronously: FSM IDLE, byte index 0, all counters 0, pkt_data 0, pkt_valid 0, busy 0, all error pulses 0, synchroniser 1.
REQ-025 Reset mid-frame or mid-packet SHALL discard all partial data; the first start bit after release begins byte 0.

Configuration
REQ-026 Macro MANDEL_CMD_RX_CHECKSUM_EN defined: a packet is NUM_BYTES+1 bytes; the last is a checksum; accepted only if the 8-bit modular sum of all NUM_BYTES+1 bytes is 0x00, else chk_err pulse and packet discarded; checksum byte not placed in pkt_data.
REQ-027 Macro undefined: packet is NUM_BYTES bytes, no checksum logic, chk_err tied to 0; port list identical in both builds.

Verification
REQ-028 Defaults, send 0x03,0x08,0xF0,0x00,0xF8,0x00,0x00,0x40,0x00,0x40 at 1040 ns/bit, pkt_ready=0 -> pkt_data=0x0308F000F80000400040, pkt_valid held; pkt_ready=1 one cycle -> pkt_valid 0 next clock.
REQ-029 Same ten bytes back-to-back with no inter-frame gap -> identical pkt_data, no frm_err.
REQ-030 Byte 3 sent with stop bit 0 -> frm_err one cycle, busy 0, then a full 10-byte packet 0x01..0x0A -> pkt_data=0x0102030405060708090A.
REQ-031 4 bytes then 20000 idle clocks -> tmo_err pulse at 16384 idle clocks; next 10 bytes form a correct packet starting at byte 0.
REQ-032 Two full packets with pkt_ready=0 -> ovr_err pulse at second completion; pkt_data still holds the first packet.
REQ-033 With MANDEL_CMD_RX_CHECKSUM_EN: packet 0x01..0x0A plus 0xC9 -> pkt_valid; plus 0xC8 -> chk_err pulse, pkt_valid stays 0.
